// File: rtl/sr_reg_bank.sv
// -----------------------------------------------------------------------------
// sr_reg_bank
//
// Bank of WIDTH independent set/reset storage bits with a run-time selectable
// policy for the s=r=1 case (hold, set-dominant, reset-dominant or toggle).
// Alongside the stored state the bank reports per-bit change pulses, sticky
// per-bit conflict flags and a saturating count of cycles with a conflict.
//
// Parameters:
//   WIDTH   number of storage bits (1..32)
//   CNT_W   width of the conflict-cycle counter (2..16)
//   RST_VAL value loaded into q on reset
//
// Ports:
//   clk            clock, all state changes on the rising edge
//   rst            synchronous active-high reset, overrides everything
//   en             update enable; 0 holds q and records no conflicts
//   mode[1:0]      s=r=1 policy: 00 hold, 01 set, 10 reset, 11 toggle
//   s, r           per-bit set / reset requests
//   clr_flag       per-bit clear of conflict_flag (acts regardless of en)
//   clr_cnt        clear of conflict_cnt (acts regardless of en)
//   q              stored state (registered)
//   q_rise/q_fall  one-cycle pulses marking a 0->1 / 1->0 change of q
//   conflict_flag  sticky per-bit record of an enabled s=r=1 request
//   conflict_any   OR of conflict_flag, registered alongside it
//   conflict_cnt   saturating count of enabled cycles with any conflict
//   cnt_sat        high while conflict_cnt is all-ones
// -----------------------------------------------------------------------------
module sr_reg_bank #(
  parameter int                 WIDTH   = 8,
  parameter int                 CNT_W   = 8,
  parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] clr_flag,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_rise,
  output logic [WIDTH-1:0] q_fall,
  output logic [WIDTH-1:0] conflict_flag,
  output logic             conflict_any,
  output logic [CNT_W-1:0] conflict_cnt,
  output logic             cnt_sat
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SET  = 2'b01,
    MODE_RST  = 2'b10,
    MODE_TOG  = 2'b11
  } conflict_mode_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Next value of one storage bit. Every path returns a defined value, so a
  // toggle from a known state can never produce X.
  function automatic logic f_next_bit(
    input logic           q_cur,
    input logic           s_b,
    input logic           r_b,
    input logic           en_b,
    input conflict_mode_t m
  );
    logic nxt;
    nxt = q_cur;
    if (en_b) begin
      unique case ({s_b, r_b})
        2'b00: nxt = q_cur;
        2'b01: nxt = 1'b0;
        2'b10: nxt = 1'b1;
        2'b11: begin
          unique case (m)
            MODE_HOLD: nxt = q_cur;
            MODE_SET:  nxt = 1'b1;
            MODE_RST:  nxt = 1'b0;
            MODE_TOG:  nxt = ~q_cur;
            default:   nxt = q_cur;
          endcase
        end
        default: nxt = q_cur;
      endcase
    end
    return nxt;
  endfunction

  // State registers
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_q_rise;
  logic [WIDTH-1:0] r_q_fall;
  logic [WIDTH-1:0] r_flag;
  logic             r_any;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;

  // Combinational next-state
  conflict_mode_t   w_mode;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_rise_next;
  logic [WIDTH-1:0] w_fall_next;
  logic [WIDTH-1:0] w_conflict;
  logic [WIDTH-1:0] w_flag_next;
  logic             w_inc;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_mode = conflict_mode_t'(mode);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign w_q_next[gi]    = f_next_bit(r_q[gi], s[gi], r[gi], en, w_mode);
      assign w_rise_next[gi] = ~r_q[gi] &  w_q_next[gi];
      assign w_fall_next[gi] =  r_q[gi] & ~w_q_next[gi];
      // A conflict is only recorded while the bank is enabled.
      assign w_conflict[gi]  = s[gi] & r[gi] & en;
      // Set wins over clear so a conflict arriving with its own clear is kept.
      assign w_flag_next[gi] = (r_flag[gi] & ~clr_flag[gi]) | w_conflict[gi];
    end
  endgenerate

  assign w_inc = |w_conflict;

  // Counter: a clear still counts a conflict seen in the same cycle, and the
  // increment stops at all-ones instead of wrapping.
  always_comb begin
    w_cnt_next = r_cnt;
    if (clr_cnt) begin
      w_cnt_next = w_inc ? CNT_ONE : CNT_ZERO;
    end else if (w_inc && (r_cnt != CNT_MAX)) begin
      w_cnt_next = r_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q      <= RST_VAL;
      r_q_rise <= {WIDTH{1'b0}};
      r_q_fall <= {WIDTH{1'b0}};
      r_flag   <= {WIDTH{1'b0}};
      r_any    <= 1'b0;
      r_cnt    <= CNT_ZERO;
      r_sat    <= 1'b0;
    end else begin
      r_q      <= w_q_next;
      r_q_rise <= w_rise_next;
      r_q_fall <= w_fall_next;
      r_flag   <= w_flag_next;
      // Derived from the flag next-state so it lines up with conflict_flag.
      r_any    <= |w_flag_next;
      r_cnt    <= w_cnt_next;
      r_sat    <= (w_cnt_next == CNT_MAX);
    end
  end

  assign q             = r_q;
  assign q_rise        = r_q_rise;
  assign q_fall        = r_q_fall;
  assign conflict_flag = r_flag;
  assign conflict_any  = r_any;
  assign conflict_cnt  = r_cnt;
  assign cnt_sat       = r_sat;

endmodule

// File: tb/tb_sr_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_sr_reg_bank
//
// Self-checking bench for sr_reg_bank (WIDTH=8, CNT_W=2, RST_VAL=8'hA5).
// A behavioural model advances on every rising edge; a compare process checks
// all DUT outputs against it on each falling edge. Directed phases add
// hand-computed literal checks, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_sr_reg_bank;

  localparam int             W       = 8;
  localparam int             CW      = 2;
  localparam logic [W-1:0]   RSTV    = 8'hA5;
  localparam int             CNT_TOP = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [W-1:0]  s = '0;
  logic [W-1:0]  r = '0;
  logic [W-1:0]  clr_flag = '0;
  logic          clr_cnt = 1'b0;
  logic [W-1:0]  q;
  logic [W-1:0]  q_rise;
  logic [W-1:0]  q_fall;
  logic [W-1:0]  conflict_flag;
  logic          conflict_any;
  logic [CW-1:0] conflict_cnt;
  logic          cnt_sat;

  sr_reg_bank #(.WIDTH(W), .CNT_W(CW), .RST_VAL(RSTV)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s), .r(r),
    .clr_flag(clr_flag), .clr_cnt(clr_cnt), .q(q), .q_rise(q_rise),
    .q_fall(q_fall), .conflict_flag(conflict_flag),
    .conflict_any(conflict_any), .conflict_cnt(conflict_cnt), .cnt_sat(cnt_sat)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_q, m_rise, m_fall, m_flag;
  logic         m_any, m_sat;
  int           m_cnt;
  bit           m_valid = 1'b0;

  // Stored value after one edge, straight from the truth table of the bank.
  function automatic logic [W-1:0] model_q(input logic [W-1:0] cur, input logic [W-1:0] sv,
                                           input logic [W-1:0] rv, input logic e, input logic [1:0] md);
    logic [W-1:0] res;
    res = cur;
    if (e) begin
      for (int i = 0; i < W; i++) begin
        if (sv[i] && !rv[i]) res[i] = 1'b1;
        else if (!sv[i] && rv[i]) res[i] = 1'b0;
        else if (sv[i] && rv[i]) begin
          if (md == 2'd1) res[i] = 1'b1;
          else if (md == 2'd2) res[i] = 1'b0;
          else if (md == 2'd3) res[i] = !cur[i];
        end
      end
    end
    return res;
  endfunction

  function automatic int model_cnt(input int cur, input bit clr, input bit inc);
    if (clr) return inc ? 1 : 0;
    if (inc && cur < CNT_TOP) return cur + 1;
    return cur;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_q     <= RSTV;
      m_rise  <= '0;
      m_fall  <= '0;
      m_flag  <= '0;
      m_any   <= 1'b0;
      m_cnt   <= 0;
      m_sat   <= 1'b0;
      m_valid <= 1'b1;
    end else if (m_valid) begin
      m_q    <= model_q(m_q, s, r, en, mode);
      m_rise <= model_q(m_q, s, r, en, mode) & ~m_q;
      m_fall <= m_q & ~model_q(m_q, s, r, en, mode);
      m_flag <= (m_flag & ~clr_flag) | (en ? (s & r) : '0);
      m_any  <= (((m_flag & ~clr_flag) | (en ? (s & r) : '0)) != '0);
      m_cnt  <= model_cnt(m_cnt, clr_cnt, en && ((s & r) != '0));
      m_sat  <= (model_cnt(m_cnt, clr_cnt, en && ((s & r) != '0)) == CNT_TOP);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("q",      32'(q),             32'(m_q));
      check("q_rise", 32'(q_rise),        32'(m_rise));
      check("q_fall", 32'(q_fall),        32'(m_fall));
      check("flag",   32'(conflict_flag), 32'(m_flag));
      check("any",    32'(conflict_any),  32'(m_any));
      check("cnt",    32'(conflict_cnt),  32'(m_cnt));
      check("sat",    32'(cnt_sat),       32'(m_sat));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [1:0] md, input logic [W-1:0] sv,
                       input logic [W-1:0] rv, input logic [W-1:0] cf, input logic cc);
    en = e; mode = md; s = sv; r = rv; clr_flag = cf; clr_cnt = cc;
  endtask

  initial begin
    logic [CW-1:0] exp_cnt [5];
    logic          exp_sat [5];
    logic [W-1:0]  exp_tq  [4];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    exp_sat = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_tq  = '{8'h0D, 8'h0C, 8'h0D, 8'h0C};

    // Reset values
    rst = 1'b1;
    tick(); tick();
    check("rst_q",    32'(q), 32'h A5);
    check("rst_puls", 32'(q_rise | q_fall), 32'h0);
    check("rst_flag", 32'({conflict_flag, conflict_any, cnt_sat}), 32'h0);
    check("rst_cnt",  32'(conflict_cnt), 32'h0);

    // Disabled: random requests must not disturb anything
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 2'($urandom_range(3)), W'($urandom), W'($urandom), '0, 1'b0);
      tick();
      check("dis_q",   32'(q), 32'hA5);
      check("dis_cnt", 32'(conflict_cnt), 32'h0);
    end

    // Basic set/reset
    drive(1'b1, 2'b00, 8'h00, 8'hFF, '0, 1'b0); tick();
    check("clr_q", 32'(q), 32'h00);
    drive(1'b1, 2'b00, 8'h0F, 8'h00, '0, 1'b0); tick();
    check("set_q", 32'(q), 32'h0F);
    check("set_rise", 32'(q_rise), 32'h0F);
    drive(1'b1, 2'b00, 8'h00, 8'h03, '0, 1'b0); tick();
    check("rsv_q", 32'(q), 32'h0C);
    check("rsv_fall", 32'(q_fall), 32'h03);
    check("rsv_rise", 32'(q_rise), 32'h00);

    // Conflict policies on bit 0
    drive(1'b1, 2'b00, 8'h01, 8'h01, '0, 1'b0); tick();
    check("m00_q", 32'(q), 32'h0C);
    check("m00_flag", 32'(conflict_flag), 32'h01);
    drive(1'b1, 2'b01, 8'h01, 8'h01, '0, 1'b0); tick();
    check("m01_q", 32'(q), 32'h0D);
    drive(1'b1, 2'b10, 8'h01, 8'h01, '0, 1'b0); tick();
    check("m10_q", 32'(q), 32'h0C);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b11, 8'h01, 8'h01, '0, 1'b0); tick();
      check("tog_q", 32'(q), 32'(exp_tq[i]));
      check("tog_rise", 32'(q_rise), (i % 2 == 0) ? 32'h01 : 32'h00);
      check("tog_fall", 32'(q_fall), (i % 2 == 0) ? 32'h00 : 32'h01);
    end

    // Clear everything
    drive(1'b1, 2'b11, 8'h00, 8'h00, 8'hFF, 1'b1); tick();
    check("clrall_cnt", 32'(conflict_cnt), 32'h0);
    check("clrall_any", 32'(conflict_any), 32'h0);

    // Sticky flag race: conflict wins over same-cycle clear
    drive(1'b1, 2'b11, 8'h08, 8'h08, 8'h08, 1'b0); tick();
    check("race_flag", 32'(conflict_flag), 32'h08);
    check("race_q", 32'(q), 32'h04);
    drive(1'b1, 2'b11, 8'h00, 8'h00, 8'h08, 1'b0); tick();
    check("race_clr", 32'(conflict_flag), 32'h00);
    check("race_any", 32'(conflict_any), 32'h0);

    // Counter saturation
    drive(1'b1, 2'b00, 8'h00, 8'h00, '0, 1'b1); tick();
    check("sat_pre", 32'(conflict_cnt), 32'h0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'b00, 8'h10, 8'h10, '0, 1'b0); tick();
      check("sat_cnt", 32'(conflict_cnt), 32'(exp_cnt[i]));
      check("sat_flag", 32'(cnt_sat), 32'(exp_sat[i]));
    end
    drive(1'b1, 2'b00, 8'h10, 8'h10, '0, 1'b1); tick();
    check("clrinc_cnt", 32'(conflict_cnt), 32'h1);
    check("clrinc_sat", 32'(cnt_sat), 32'h0);

    // Reset in the middle of toggling
    drive(1'b1, 2'b11, 8'hFF, 8'hFF, '0, 1'b0); tick(); tick();
    rst = 1'b1; tick();
    check("mrst_q", 32'(q), 32'hA5);
    check("mrst_puls", 32'(q_rise | q_fall), 32'h0);
    check("mrst_cnt", 32'(conflict_cnt), 32'h0);
    rst = 1'b0; tick();
    check("post_q", 32'(q), 32'h5A);
    check("post_rise", 32'(q_rise), 32'h5A);
    check("post_fall", 32'(q_fall), 32'hA5);

    // Randomized phase, checked by the model each cycle
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(31) == 0);
      drive($urandom_range(3) != 0, 2'($urandom_range(3)), W'($urandom), W'($urandom),
            ($urandom_range(7) == 0) ? W'($urandom) : '0, $urandom_range(7) == 0);
      tick();
    end
    rst = 1'b0;
    drive(1'b0, 2'b00, '0, '0, '0, 1'b0);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
